meas_frame_tx: RTL

//  Parametrised successor to the fixed 64-bit/8-bit measurement-to-UART path. Accepts whole

---
 rtl/meas_pkg.sv | 16 +
 rtl/meas_rec_fifo.sv | 52 +++++
 rtl/meas_frame_tx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/meas_pkg.sv
// Shared types and constants for the measurement frame transmitter.
package meas_pkg;

  // Frame serialiser states
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWait,
    StDone
  } state_e;

  localparam int unsigned CSUM_W      = 8;
  localparam logic [7:0]  HDR_DEFAULT = 8'hA5;

endpackage

// File: rtl/meas_rec_fifo.sv
// Synchronous record FIFO with registered read data and occupancy output.
module meas_rec_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and read-data registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) begin
        rd_ptr  <= rd_ptr + (AW+1)'(1);
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/meas_frame_tx.sv
// Buffers measurement records and serialises each as [HDR][data MSB-first][~CSUM]
// to a byte UART using its enable/busy handshake.
module meas_frame_tx
  import meas_pkg::*;
#(
  parameter int unsigned REC_BYTES = 8,
  parameter int unsigned DEPTH     = 4,
  parameter bit          HDR_EN    = 1'b1,
  parameter logic [7:0]  HDR_BYTE  = HDR_DEFAULT,
  parameter bit          CSUM_EN   = 1'b1,
  parameter int unsigned BUSY_TO   = 16
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       rec_valid,
  input  logic [REC_BYTES*8-1:0]     rec_data,
  output logic                       rec_ready,
  output logic [7:0]                 tx_byte,
  output logic                       tx_en,
  input  logic                       tx_busy,
  output logic                       frame_done,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [15:0]                overflow_cnt
);

  localparam int unsigned REC_W  = REC_BYTES * 8;
  localparam int unsigned NBYTES = REC_BYTES + (HDR_EN ? 1 : 0) + (CSUM_EN ? 1 : 0);
  localparam int unsigned IDX_W  = $clog2(NBYTES + 1);
  localparam int unsigned TO_W   = $clog2(BUSY_TO + 1);

  state_e             state_q, state_d;
  logic [REC_W-1:0]   shreg_q, shreg_d;
  logic [CSUM_W-1:0]  csum_q, csum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               seen_q, seen_d;
  logic [7:0]         tx_byte_d;
  logic               tx_en_d;
  logic               byte_sent;
  logic               last_byte;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [REC_W-1:0]   fifo_rd_data;

  meas_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .push    (rec_valid),
    .pop     (fifo_pop),
    .wr_data (rec_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Readiness comes from registered pointers, so a same-cycle pop never frees a slot early
  assign rec_ready  = !fifo_full;
  assign fifo_pop   = (state_q == StIdle) && !fifo_empty && !tx_busy;
  assign frame_done = (state_q == StDone);
  assign last_byte  = (idx_q == IDX_W'(NBYTES - 1));

  // Saturating count of records offered while full
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      overflow_cnt <= '0;
    end else if (rec_valid && fifo_full && (overflow_cnt != 16'hFFFF)) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      csum_q  <= '0;
      idx_q   <= '0;
      to_q    <= '0;
      seen_q  <= 1'b0;
      tx_byte <= '0;
      tx_en   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
      seen_q  <= seen_d;
      tx_byte <= tx_byte_d;
      tx_en   <= tx_en_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    csum_d    = csum_q;
    idx_d     = idx_q;
    to_d      = to_q;
    seen_d    = seen_q;
    tx_byte_d = tx_byte;
    tx_en_d   = 1'b0;
    byte_sent = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fifo_pop) state_d = StLoad;
      end
      StLoad: begin
        // FIFO read data is registered: valid now, one cycle after the pop
        shreg_d = fifo_rd_data;
        csum_d  = '0;
        idx_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        if (!tx_busy) begin
          tx_en_d = 1'b1;
          to_d    = '0;
          seen_d  = 1'b0;
          state_d = StWait;
          if (HDR_EN && (idx_q == '0)) begin
            tx_byte_d = HDR_BYTE;
          end else if (CSUM_EN && last_byte) begin
            tx_byte_d = ~csum_q;
          end else begin
            tx_byte_d = shreg_q[REC_W-1 -: 8];
            csum_d    = csum_q + shreg_q[REC_W-1 -: 8];
            shreg_d   = shreg_q << 8;
          end
        end
      end
      StWait: begin
        // Byte is complete on busy fall, or on timeout if busy never rose
        if (seen_q) begin
          byte_sent = !tx_busy;
        end else if (tx_busy) begin
          seen_d = 1'b1;
        end else if (to_q == TO_W'(BUSY_TO - 1)) begin
          byte_sent = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
        if (byte_sent) begin
          if (last_byte) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = StSend;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
